// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered 1-to-N stream demultiplexer.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        DROP   = 2'd2
    } state_t;

    localparam int BUS_MAX_W   = 512;
    localparam int SLICE_MAX_W = 32;

    // Slice k of width w out of a flattened bus (zero-padded to BUS_MAX_W).
    function automatic logic [SLICE_MAX_W-1:0] bus_slice(
        input logic [BUS_MAX_W-1:0] bus,
        input int                   k,
        input int                   w
    );
        logic [BUS_MAX_W-1:0]   sh;
        logic [SLICE_MAX_W-1:0] mask;
        sh   = bus >> (k * w);
        mask = (w >= SLICE_MAX_W) ? '1 : ((SLICE_MAX_W'(1) << w) - SLICE_MAX_W'(1));
        return sh[SLICE_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// Single-entry output register for one demux channel: a write wins over a
// drain, so a same-cycle drain+write keeps the slot full with the new beat.
module demux_chan_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              rd_ready,
    output logic              vld,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
            last <= 1'b0;
        end else if (wr_en) begin
            vld  <= 1'b1;
            data <= wr_data;
            last <= wr_last;
        end else if (vld && rd_ready) begin
            vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered, packet-locked 1-to-N stream demux: the head beat picks the
// channel, later beats follow it until in_last; bad heads drop the packet.
module stream_demux_1xn
    import stream_demux_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_last,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_last,
    output logic                     sel_err
);

    localparam logic [SEL_W:0] N_CH_L = (SEL_W+1)'(N_CH);

    state_t                      state, state_nxt;
    logic [SEL_W-1:0]            lock_sel, lock_nxt, tgt;
    logic                        tgt_free, head_ok, wr_go, sel_err_nxt;
    logic [N_CH-1:0]             wr_en, chan_free;
    logic [N_CH-1:0][DATA_W-1:0] chan_data;

    assign tgt     = (state == LOCKED) ? lock_sel : in_sel;
    assign head_ok = {1'b0, in_sel} < N_CH_L;

    // A target slot can take a beat when empty or being drained this cycle.
    always_comb begin
        tgt_free = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (tgt == SEL_W'(k)) tgt_free = chan_free[k];
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        assign chan_free[k] = !out_valid[k] || out_ready[k];
        assign wr_en[k]     = wr_go && (tgt == SEL_W'(k));

        demux_chan_reg #(.DATA_W(DATA_W)) u_reg (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[k]),
            .wr_data  (in_data),
            .wr_last  (in_last),
            .rd_ready (out_ready[k]),
            .vld      (out_valid[k]),
            .data     (chan_data[k]),
            .last     (out_last[k])
        );
    end

    assign out_data = chan_data;

    always_comb begin
        state_nxt   = state;
        lock_nxt    = lock_sel;
        in_ready    = 1'b0;
        wr_go       = 1'b0;
        sel_err_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = head_ok ? tgt_free : 1'b1;
                if (in_valid && in_ready) begin
                    if (head_ok) begin
                        wr_go    = 1'b1;
                        lock_nxt = in_sel;
                        if (!in_last) state_nxt = LOCKED;
                    end else begin
                        sel_err_nxt = 1'b1;
                        if (!in_last) state_nxt = DROP;
                    end
                end
            end
            LOCKED: begin
                in_ready = tgt_free;
                if (in_valid && in_ready) begin
                    wr_go = 1'b1;
                    if (in_last) state_nxt = IDLE;
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_sel <= '0;
            sel_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_sel <= lock_nxt;
            sel_err  <= sel_err_nxt;
        end
    end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Randomized scoreboard bench for stream_demux_1xn (8-channel main DUT plus a
// 6-channel instance for out-of-range select handling).
module tb_stream_demux_1xn;
    import stream_demux_pkg::*;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 3;
    localparam int N6 = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            in_valid, in_ready, in_last, sel_err;
    logic [W-1:0]    in_data;
    logic [SW-1:0]   in_sel;
    logic [N-1:0]    out_valid, out_ready, out_last;
    logic [N*W-1:0]  out_data;

    logic            v6, r6, l6, se6;
    logic [W-1:0]    d6;
    logic [2:0]      s6;
    logic [N6-1:0]   ov6, or6, ol6;
    logic [N6*W-1:0] od6;

    stream_demux_1xn #(.N_CH(N), .DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .sel_err(sel_err)
    );

    stream_demux_1xn #(.N_CH(N6), .DATA_W(W)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(r6),
        .in_data(d6), .in_sel(s6), .in_last(l6),
        .out_valid(ov6), .out_ready(or6), .out_data(od6),
        .out_last(ol6), .sel_err(se6)
    );

    typedef struct {
        int           ch;
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    dlv[N];
    int    rdy_mode[N];   // 0 random, 1 always ready, 2 never ready

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] chan_of(input logic [BUS_MAX_W-1:0] pad, input int k);
        logic [SLICE_MAX_W-1:0] s;
        s = bus_slice(pad, k, W);
        return s[W-1:0];
    endfunction

    // Consumer: applies the per-channel ready policy each cycle.
    initial begin
        out_ready = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < N; k++) begin
                case (rdy_mode[k])
                    0:       out_ready[k] = 1'($urandom_range(0, 1));
                    1:       out_ready[k] = 1'b1;
                    default: out_ready[k] = 1'b0;
                endcase
            end
        end
    end

    // Reference model + monitor, evaluated mid-cycle when all handshakes are stable.
    bit                   mdl_open, mdl_drop;
    int                   mdl_ch, occ[N], tgt, idx;
    bit                   exp_rdy;
    logic [W-1:0]         prev_data[N];
    bit                   prev_stall[N];
    logic [BUS_MAX_W-1:0] pad;
    logic [W-1:0]         got;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            mdl_open = 1'b0;
            mdl_drop = 1'b0;
            for (int k = 0; k < N; k++) prev_stall[k] = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) occ[k] = 0;
            foreach (sb[i]) occ[sb[i].ch]++;
            pad = '0;
            pad[N*W-1:0] = out_data;
            for (int k = 0; k < N; k++) begin
                got = chan_of(pad, k);
                check($sformatf("valid_ch%0d", k), 32'(out_valid[k]), 32'(occ[k] > 0));
                if (out_valid[k] && prev_stall[k])
                    check($sformatf("hold_ch%0d", k), 32'(got), 32'(prev_data[k]));
                prev_stall[k] = out_valid[k] && !out_ready[k];
                prev_data[k]  = got;
                if (out_valid[k] && out_ready[k]) begin
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (sb[i].ch == k) begin
                            idx = i;
                            break;
                        end
                    end
                    if (idx < 0) begin
                        check($sformatf("spurious_ch%0d", k), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("data_ch%0d", k), 32'(got), 32'(sb[idx].data));
                        check($sformatf("last_ch%0d", k), 32'(out_last[k]), 32'(sb[idx].last));
                        sb.delete(idx);
                        dlv[k]++;
                    end
                end
            end
            check("sel_err_n8", 32'(sel_err), 32'd0);
            if (in_valid) begin
                tgt = mdl_open ? mdl_ch : int'(in_sel);
                if (mdl_open && mdl_drop) exp_rdy = 1'b1;
                else if (tgt >= N)       exp_rdy = 1'b1;
                else                     exp_rdy = (occ[tgt] == 0) || out_ready[tgt];
                check("in_ready", 32'(in_ready), 32'(exp_rdy));
                if (in_ready) begin
                    if (!mdl_open) begin
                        mdl_ch   = tgt;
                        mdl_drop = (tgt >= N);
                    end
                    if (!mdl_drop) sb.push_back('{mdl_ch, in_data, in_last});
                    mdl_open = !in_last;
                end
            end
        end
    end

    // Present one beat and hold it until accepted; called just after a rising edge.
    task automatic send_beat(input int sel, input logic [W-1:0] data, input bit last, output int waits);
        in_valid = 1'b1;
        in_sel   = SW'(sel);
        in_data  = data;
        in_last  = last;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 1000) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    int                   w, w1, wsum, d0, d2, se_cnt;
    bit                   any_ov;
    logic [BUS_MAX_W-1:0] pad6;

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sel = '0; in_last = 1'b0;
        v6 = 1'b0; d6 = '0; s6 = '0; l6 = 1'b0; or6 = '1;
        for (int k = 0; k < N; k++) begin
            rdy_mode[k] = 1;
            dlv[k] = 0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  out_data[31:0], 32'd0);
        check("rst_last",  32'(out_last), 32'd0);
        check("rst_selerr", 32'(se6), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat sweep: one-hot valid on the selected channel.
        for (int s = 0; s < N; s++) begin
            send_beat(s, W'(8'hA0 + s), 1'b1, w);
            check($sformatf("onehot_%0d", s), 32'(out_valid), 32'(1 << s));
        end

        // Packet lock: head to 5, later beats carry in_sel=2.
        d2 = dlv[2];
        for (int i = 0; i < 4; i++) send_beat((i == 0) ? 5 : 2, W'(8'h50 + i), i == 3, w);
        repeat (3) @(posedge clk);
        #1;
        check("lock_ch2_idle", 32'(dlv[2]), 32'(d2));

        // Backpressure on ch1, then a packet to ch6 passes while ch1 stays stalled.
        rdy_mode[1] = 2;
        @(posedge clk);
        #1;
        send_beat(1, 8'h10, 1'b0, w);
        fork
            send_beat(1, 8'h11, 1'b1, w1);
            begin
                repeat (5) @(posedge clk);
                #1 rdy_mode[1] = 1;
                @(posedge clk);
                #1 rdy_mode[1] = 2;
            end
        join
        check("stall_cycles", 32'(w1), 32'd5);
        send_beat(6, 8'h66, 1'b1, w);
        check("ch6_no_wait", 32'(w), 32'd0);
        check("ch1_still_held", 32'(out_valid[1]), 32'd1);
        rdy_mode[1] = 1;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-packet: held beat lost, next beat is a head.
        rdy_mode[2] = 2;
        send_beat(2, 8'h55, 1'b0, w);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data",  out_data[31:0], 32'd0);
        rdy_mode[2] = 1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(3, 8'h33, 1'b1, w);
        check("post_rst_lat", 32'(out_valid), 32'h08);

        // Continuous 16-beat packet into ch0: no bubbles, nothing lost.
        d0 = dlv[0];
        wsum = 0;
        for (int i = 0; i < 16; i++) begin
            send_beat(0, W'(i), i == 15, w);
            wsum += w;
        end
        check("ch0_bubbles", 32'(wsum), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("ch0_count", 32'(dlv[0] - d0), 32'd16);

        // 6-channel instance: out-of-range head drops a 3-beat packet.
        se_cnt = 0;
        any_ov = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v6 = 1'b1; s6 = (i == 0) ? 3'd7 : 3'(i); d6 = W'(i); l6 = (i == 2);
            @(negedge clk);
            check($sformatf("drop_rdy_%0d", i), 32'(r6), 32'd1);
            se_cnt += int'(se6);
            any_ov |= |ov6;
            @(posedge clk);
            #1;
        end
        v6 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            se_cnt += int'(se6);
            any_ov |= |ov6;
        end
        check("selerr_pulses", 32'(se_cnt), 32'd1);
        check("drop_no_valid", 32'(any_ov), 32'd0);
        @(posedge clk);
        #1;
        v6 = 1'b1; s6 = 3'd6; d6 = 8'hEE; l6 = 1'b1;
        @(posedge clk);
        #1;
        s6 = 3'd4; d6 = 8'h44;
        @(negedge clk);
        check("n6_head_rdy", 32'(r6), 32'd1);
        @(posedge clk);
        #1;
        v6 = 1'b0;
        pad6 = '0;
        pad6[N6*W-1:0] = od6;
        check("n6_valid", 32'(ov6), 32'h10);
        check("n6_data", 32'(chan_of(pad6, 4)), 32'h44);
        check("n6_last", 32'(ol6[4]), 32'd1);

        // Randomized packets with random consumer backpressure.
        for (int p = 0; p < 40; p++) begin
            for (int k = 0; k < N; k++) rdy_mode[k] = int'($urandom_range(0, 1));
            begin
                int sel, len;
                sel = int'($urandom_range(0, N - 1));
                len = int'($urandom_range(1, 4));
                for (int i = 0; i < len; i++) send_beat(sel, W'($urandom), i == len - 1, w);
            end
        end

        for (int k = 0; k < N; k++) rdy_mode[k] = 1;
        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
